// File: rtl/urng_taus_multi.sv
// Multi-channel taus88 uniform random source: NCH independent generators stepped in lockstep,
// one NCH-wide sample per valid/ready transfer, with run-time seed load and a warm-up phase.
module urng_taus_multi #(
    parameter int NCH    = 4,
    parameter int OUT_W  = 32,
    parameter int WARMUP = 8,
    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 seed_valid,
    output logic                 seed_ready,
    input  logic [CH_W-1:0]      seed_ch,
    input  logic [95:0]          seed_data,
    output logic                 rnd_valid,
    input  logic                 rnd_ready,
    output logic [NCH*OUT_W-1:0] rnd_data,
    output logic                 busy,
    output logic [31:0]          sample_cnt
);

    // state  | meaning
    // IDLE   | seeds writable, generators frozen
    // WARMUP | all channels step, output discarded, counts down WARMUP steps
    // RUN    | one step per produced sample; drains the held sample when enable drops
    typedef enum logic [1:0] {ST_IDLE, ST_WARMUP, ST_RUN} state_t;

    state_t                   state_q, state_d;
    logic [7:0]               wcnt_q, wcnt_d;
    logic [NCH-1:0][31:0]     s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [NCH-1:0][31:0]     n1, n2, n3;
    logic                     rnd_valid_q, rnd_valid_d;
    logic [NCH*OUT_W-1:0]     rnd_data_q, rnd_data_d;
    logic [31:0]              sample_cnt_q, sample_cnt_d;
    logic                     step;

    // Raise a component into its legal range (taus88 needs s1>=2, s2>=8, s3>=16).
    function automatic logic [31:0] legalise(input logic [31:0] v, input logic [31:0] lim);
        return (v < lim) ? (v | lim) : v;
    endfunction

    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            n1[c] = ((s1_q[c] & 32'hFFFF_FFFE) << 12) ^ (((s1_q[c] << 13) ^ s1_q[c]) >> 19);
            n2[c] = ((s2_q[c] & 32'hFFFF_FFF8) << 4)  ^ (((s2_q[c] << 2)  ^ s2_q[c]) >> 25);
            n3[c] = ((s3_q[c] & 32'hFFFF_FFF0) << 17) ^ (((s3_q[c] << 3)  ^ s3_q[c]) >> 11);
        end
    end

    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        s1_d         = s1_q;
        s2_d         = s2_q;
        s3_d         = s3_q;
        rnd_valid_d  = rnd_valid_q;
        rnd_data_d   = rnd_data_q;
        sample_cnt_d = sample_cnt_q + {31'd0, rnd_valid_q & rnd_ready};
        step         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (seed_valid) begin
                    for (int c = 0; c < NCH; c++) begin
                        if (seed_ch == CH_W'(c)) begin
                            s1_d[c] = legalise(seed_data[31:0],  32'd2);
                            s2_d[c] = legalise(seed_data[63:32], 32'd8);
                            s3_d[c] = legalise(seed_data[95:64], 32'd16);
                        end
                    end
                end
                if (enable) begin
                    wcnt_d  = 8'(WARMUP);
                    state_d = (WARMUP == 0) ? ST_RUN : ST_WARMUP;
                end
            end
            ST_WARMUP: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else begin
                    step   = 1'b1;
                    wcnt_d = wcnt_q - 8'd1;
                    if (wcnt_q == 8'd1) state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (enable) begin
                    if (!rnd_valid_q || rnd_ready) begin
                        step        = 1'b1;
                        rnd_valid_d = 1'b1;
                        for (int c = 0; c < NCH; c++)
                            rnd_data_d[c*OUT_W +: OUT_W] =
                                n1[c][31 -: OUT_W] ^ n2[c][31 -: OUT_W] ^ n3[c][31 -: OUT_W];
                    end
                end else if (!rnd_valid_q || rnd_ready) begin
                    rnd_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (step) begin
            s1_d = n1;
            s2_d = n2;
            s3_d = n3;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            wcnt_q       <= 8'd0;
            rnd_valid_q  <= 1'b0;
            rnd_data_q   <= '0;
            sample_cnt_q <= 32'd0;
            for (int c = 0; c < NCH; c++) begin
                s1_q[c] <= 32'h0000_3039 + 32'(c);
                s2_q[c] <= 32'h0001_0932 + 32'(c);
                s3_q[c] <= 32'h00BC_614E + 32'(c);
            end
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            rnd_valid_q  <= rnd_valid_d;
            rnd_data_q   <= rnd_data_d;
            sample_cnt_q <= sample_cnt_d;
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            s3_q         <= s3_d;
        end
    end

    assign seed_ready = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign rnd_valid  = rnd_valid_q;
    assign rnd_data   = rnd_data_q;
    assign sample_cnt = sample_cnt_q;

endmodule

// File: tb/tb_urng_taus_multi.sv
// Directed bench for urng_taus_multi: a WARMUP=0/OUT_W=16 instance and a WARMUP=8/OUT_W=32
// instance, both checked against a reference taus88 model.
module tb_urng_taus_multi;

    logic         clk = 1'b0;
    logic         reset;

    logic         enable, seed_valid, rnd_ready;
    logic [1:0]   seed_ch;
    logic [95:0]  seed_data;
    logic         seed_ready, rnd_valid, busy;
    logic [127:0] rnd_data;
    logic [31:0]  sample_cnt;

    logic         en0, seed_valid0, rdy0;
    logic [1:0]   seed_ch0;
    logic [95:0]  seed_data0;
    logic         seed_ready0, rnd_valid0, busy0;
    logic [63:0]  rnd_data0;
    logic [31:0]  sample_cnt0;

    int checks = 0;
    int errors = 0;
    int xfers  = 0;

    logic [95:0]  m  [4];
    logic [95:0]  m0 [4];
    logic [127:0] exp_main;
    logic [63:0]  exp0;

    always #5 clk = ~clk;

    urng_taus_multi #(.NCH(4), .OUT_W(32), .WARMUP(8)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .seed_valid(seed_valid), .seed_ready(seed_ready), .seed_ch(seed_ch), .seed_data(seed_data),
        .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd_data(rnd_data),
        .busy(busy), .sample_cnt(sample_cnt)
    );

    urng_taus_multi #(.NCH(4), .OUT_W(16), .WARMUP(0)) dut0 (
        .clk(clk), .reset(reset), .enable(en0),
        .seed_valid(seed_valid0), .seed_ready(seed_ready0), .seed_ch(seed_ch0), .seed_data(seed_data0),
        .rnd_valid(rnd_valid0), .rnd_ready(rdy0), .rnd_data(rnd_data0),
        .busy(busy0), .sample_cnt(sample_cnt0)
    );

    function automatic logic [95:0] tstep(input logic [95:0] s);
        logic [31:0] a, b, d, na, nb, nd;
        a  = s[31:0];
        b  = s[63:32];
        d  = s[95:64];
        na = ((a & 32'hFFFF_FFFE) << 12) ^ (((a << 13) ^ a) >> 19);
        nb = ((b & 32'hFFFF_FFF8) << 4)  ^ (((b << 2)  ^ b) >> 25);
        nd = ((d & 32'hFFFF_FFF0) << 17) ^ (((d << 3)  ^ d) >> 11);
        return {nd, nb, na};
    endfunction

    function automatic logic [31:0] tres(input logic [95:0] s);
        return s[31:0] ^ s[63:32] ^ s[95:64];
    endfunction

    function automatic logic [95:0] dflt(input int c);
        return {32'h00BC_614E + 32'(c), 32'h0001_0932 + 32'(c), 32'h0000_3039 + 32'(c)};
    endfunction

    task automatic step_main();
        for (int c = 0; c < 4; c++) begin
            m[c] = tstep(m[c]);
            exp_main[c*32 +: 32] = tres(m[c]);
        end
    endtask

    task automatic step0();
        logic [31:0] r;
        for (int c = 0; c < 4; c++) begin
            m0[c] = tstep(m0[c]);
            r = tres(m0[c]);
            exp0[c*16 +: 16] = r[31:16];
        end
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        enable = 0; seed_valid = 0; rnd_ready = 0; seed_ch = 0; seed_data = '0;
        en0 = 0; seed_valid0 = 0; rdy0 = 0; seed_ch0 = 0; seed_data0 = '0;
        for (int c = 0; c < 4; c++) begin
            m[c]  = dflt(c);
            m0[c] = dflt(c);
        end
        tick();
        tick();
        chk("rst_valid", rnd_valid, 0);
        chk("rst_data", rnd_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", sample_cnt, 0);
        chk("rst_seed_ready", seed_ready, 1);
        chk("rst0_valid", rnd_valid0, 0);
        chk("rst0_seed_ready", seed_ready0, 1);
        reset = 1'b1;
        tick();

        // WARMUP=0 instance: first sample right after edge 1, full-rate stream
        en0 = 1; rdy0 = 1;
        tick();
        chk("d0_valid_edge0", rnd_valid0, 0);
        chk("d0_busy", busy0, 1);
        for (int k = 1; k <= 1000; k++) begin
            tick();
            step0();
            chk("d0_valid", rnd_valid0, 1);
            chk("d0_data", rnd_data0, exp0);
        end
        chk("d0_cnt999", sample_cnt0, 999);
        en0 = 0;
        tick();
        chk("d0_idle_valid", rnd_valid0, 0);
        chk("d0_idle_busy", busy0, 0);

        // zero seed written in the same cycle as enable: legalised to 2/8/16
        seed_valid0 = 1; seed_ch0 = 2; seed_data0 = '0; en0 = 1;
        tick();
        seed_valid0 = 0;
        m0[2] = {32'd16, 32'd8, 32'd2};
        tick();
        step0();
        chk("d0_zero_seed_hand", rnd_data0[47:32], 16'h0020);
        chk("d0_after_seed", rnd_data0, exp0);
        en0 = 0;
        tick();

        // WARMUP=8 instance: seed channel 2 with zero, then warm up
        chk("seed_ready_idle", seed_ready, 1);
        seed_valid = 1; seed_ch = 2; seed_data = '0;
        tick();
        seed_valid = 0;
        m[2] = {32'd16, 32'd8, 32'd2};
        enable = 1; rnd_ready = 1;
        tick();
        chk("warm_busy", busy, 1);
        chk("warm_seed_ready", seed_ready, 0);
        seed_valid = 1; seed_ch = 1; seed_data = {3{32'hDEAD_BEEF}};
        for (int k = 1; k <= 8; k++) begin
            tick();
            step_main();
            chk("warm_valid_low", rnd_valid, 0);
        end
        tick();
        step_main();
        chk("warm_first_valid", rnd_valid, 1);
        chk("warm_first_data", rnd_data, exp_main);
        chk("run_seed_ready", seed_ready, 0);

        // random backpressure; seed writes keep being offered and must be ignored
        for (int i = 0; i < 200; i++) begin
            logic r;
            r = 1'($urandom_range(0, 1));
            rnd_ready = r;
            tick();
            if (r) begin
                step_main();
                xfers++;
            end
            chk("bp_valid", rnd_valid, 1);
            chk("bp_data", rnd_data, exp_main);
        end
        seed_valid = 0;
        chk("bp_cnt", sample_cnt, 32'(xfers));

        // stop with a held sample, drain, restart
        rnd_ready = 0; enable = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("stop_hold_valid", rnd_valid, 1);
            chk("stop_hold_busy", busy, 1);
            chk("stop_hold_data", rnd_data, exp_main);
        end
        rnd_ready = 1;
        tick();
        xfers++;
        chk("stop_valid", rnd_valid, 0);
        chk("stop_busy", busy, 0);
        chk("stop_seed_ready", seed_ready, 1);
        enable = 1;
        tick();
        for (int k = 1; k <= 8; k++) begin
            tick();
            step_main();
        end
        chk("restart_valid_low", rnd_valid, 0);
        tick();
        step_main();
        chk("restart_valid", rnd_valid, 1);
        chk("restart_data", rnd_data, exp_main);
        for (int i = 0; i < 5; i++) begin
            tick();
            step_main();
            xfers++;
            chk("restart_stream", rnd_data, exp_main);
        end
        chk("restart_cnt", sample_cnt, 32'(xfers));

        // sample counter wrap
        enable = 0;
        tick();
        force dut.sample_cnt_q = 32'hFFFF_FFFE;
        tick();
        release dut.sample_cnt_q;
        tick();
        chk("wrap_preset", sample_cnt, 32'hFFFF_FFFE);
        enable = 1;
        tick();
        for (int k = 0; k < 9; k++) tick();
        chk("wrap_first_valid", rnd_valid, 1);
        chk("wrap_before", sample_cnt, 32'hFFFF_FFFE);
        tick();
        chk("wrap_max", sample_cnt, 32'hFFFF_FFFF);
        tick();
        chk("wrap_zero", sample_cnt, 0);

        // reset in the middle of RUN restores defaults and seeds
        reset = 1'b0;
        tick();
        chk("mid_rst_valid", rnd_valid, 0);
        chk("mid_rst_data", rnd_data, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cnt", sample_cnt, 0);
        chk("mid_rst_seed_ready", seed_ready, 1);
        reset = 1'b1;
        for (int c = 0; c < 4; c++) m[c] = dflt(c);
        tick();
        for (int k = 1; k <= 8; k++) begin
            tick();
            step_main();
        end
        tick();
        step_main();
        chk("post_rst_valid", rnd_valid, 1);
        chk("post_rst_data", rnd_data, exp_main);
        enable = 0;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
